// File: rtl/approx_err_meter_if.sv
// Operand/result bus of the approximate-adder error meter.
// master drives operands and handshakes; slave is the meter.
interface approx_err_meter_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] err_sum;
  logic [4:0]  err_max;
  logic [10:0] err_cnt;
  logic        busy;

  modport master (
    output start, in_valid, a, b, res_ready,
    input  in_ready, res_valid, err_sum, err_max, err_cnt, busy
  );

  modport slave (
    input  start, in_valid, a, b, res_ready,
    output in_ready, res_valid, err_sum, err_max, err_cnt, busy
  );
endinterface

// File: rtl/approx_err_meter.sv
// Measures |exact - approx| statistics of a lower-part-OR 4-bit adder over an
// N-sample window: error registered on accept, accumulated on the next edge.
module approx_err_meter #(
  parameter int unsigned P = 2,
  parameter int unsigned N = 16
) (
  input logic               clk,
  input logic               rst_n,
  approx_err_meter_if.slave bus
);
  localparam int unsigned OP_W  = 4;
  localparam int unsigned SUM_W = OP_W + 1;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned CNT_W = 11;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e             state_q;
  logic               in_ready_q;
  logic               res_valid_q;
  logic               busy_q;
  logic [ACC_W-1:0]   err_sum_q;
  logic [SUM_W-1:0]   err_max_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   smp_cnt_q;
  logic               s1_valid_q;
  logic [SUM_W-1:0]   s1_err_q;

  logic [SUM_W-1:0]   exact_c;
  logic [SUM_W-1:0]   approx_c;
  logic [SUM_W-1:0]   err_d;
  logic               carry_c;
  logic               accept_c;

  assign accept_c = bus.in_valid & in_ready_q;

  // Low P bits are OR-ed; the carry into bit P comes from the top approximated bit's AND.
  always_comb begin
    exact_c  = SUM_W'(bus.a) + SUM_W'(bus.b);
    approx_c = '0;
    carry_c  = 1'b0;
    for (int i = 0; i < int'(OP_W); i++) begin
      if (i < int'(P)) begin
        approx_c[i] = bus.a[i] | bus.b[i];
        carry_c     = bus.a[i] & bus.b[i];
      end else begin
        approx_c[i] = bus.a[i] ^ bus.b[i] ^ carry_c;
        carry_c     = (bus.a[i] & bus.b[i]) | (carry_c & (bus.a[i] ^ bus.b[i]));
      end
    end
    approx_c[OP_W] = carry_c;
    err_d = (exact_c >= approx_c) ? (exact_c - approx_c) : (approx_c - exact_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_sum_q   <= '0;
      err_max_q   <= '0;
      err_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= '0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) begin
        s1_err_q <= err_d;
      end

      if (s1_valid_q) begin
        err_sum_q <= err_sum_q + ACC_W'(s1_err_q);
        if (s1_err_q > err_max_q) begin
          err_max_q <= s1_err_q;
        end
        if (s1_err_q != '0) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= RUN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            err_sum_q  <= '0;
            err_max_q  <= '0;
            err_cnt_q  <= '0;
            smp_cnt_q  <= '0;
          end
        end
        RUN: begin
          if (accept_c) begin
            smp_cnt_q <= smp_cnt_q + CNT_W'(1);
            if (smp_cnt_q == CNT_W'(N - 1)) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state_q     <= DONE;
          res_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;
  assign bus.err_sum   = err_sum_q;
  assign bus.err_max   = err_max_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_approx_err_meter.sv
// Directed bench for approx_err_meter: three configurations share one stimulus
// bus (only the selected instance sees handshakes), checked against an edge-level model.
module tb_approx_err_meter;
  localparam int NI = 3;
  localparam int PV [NI] = '{2, 0, 3};
  localparam int NV [NI] = '{4, 8, 1};
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic t_start, t_valid, t_res_ready;
  logic [3:0] t_a, t_b;
  int sel;
  bit chk_en = 1'b0;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  approx_err_meter_if if0 ();
  approx_err_meter_if if1 ();
  approx_err_meter_if if2 ();

  approx_err_meter #(.P(2), .N(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  approx_err_meter #(.P(0), .N(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  approx_err_meter #(.P(3), .N(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.start     = (sel == 0) ? t_start : 1'b0;
  assign if1.start     = (sel == 1) ? t_start : 1'b0;
  assign if2.start     = (sel == 2) ? t_start : 1'b0;
  assign if0.in_valid  = (sel == 0) ? t_valid : 1'b0;
  assign if1.in_valid  = (sel == 1) ? t_valid : 1'b0;
  assign if2.in_valid  = (sel == 2) ? t_valid : 1'b0;
  assign if0.res_ready = (sel == 0) ? t_res_ready : 1'b0;
  assign if1.res_ready = (sel == 1) ? t_res_ready : 1'b0;
  assign if2.res_ready = (sel == 2) ? t_res_ready : 1'b0;
  assign if0.a = t_a;
  assign if1.a = t_a;
  assign if2.a = t_a;
  assign if0.b = t_b;
  assign if1.b = t_b;
  assign if2.b = t_b;

  logic        d_in_ready, d_res_valid, d_busy;
  logic [15:0] d_sum;
  logic [4:0]  d_max;
  logic [10:0] d_cnt;
  assign d_in_ready  = (sel == 0) ? if0.in_ready  : (sel == 1) ? if1.in_ready  : if2.in_ready;
  assign d_res_valid = (sel == 0) ? if0.res_valid : (sel == 1) ? if1.res_valid : if2.res_valid;
  assign d_busy      = (sel == 0) ? if0.busy      : (sel == 1) ? if1.busy      : if2.busy;
  assign d_sum       = (sel == 0) ? if0.err_sum   : (sel == 1) ? if1.err_sum   : if2.err_sum;
  assign d_max       = (sel == 0) ? if0.err_max   : (sel == 1) ? if1.err_max   : if2.err_max;
  assign d_cnt       = (sel == 0) ? if0.err_cnt   : (sel == 1) ? if1.err_cnt   : if2.err_cnt;

  // Arithmetic definition of the approximate sum and its error.
  function automatic int err_model(input int x, input int y, input int p);
    int lo, cin, apx, ex;
    lo  = (x | y) & ((1 << p) - 1);
    cin = (p > 0) ? ((x >> (p - 1)) & (y >> (p - 1)) & 1) : 0;
    apx = lo + (((x >> p) + (y >> p) + cin) << p);
    ex  = x + y;
    return (ex >= apx) ? ex - apx : apx - ex;
  endfunction

  typedef struct {
    int due;
    int inst;
    int err;
  } pend_t;

  pend_t pend[$];
  pend_t m_e;
  int edge_n = 0;
  int m_phase[NI];
  int m_sum[NI];
  int m_max[NI];
  int m_cnt[NI];
  int m_n[NI];

  // Each accepted error lands in the accumulators exactly one edge after its accept edge.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_phase[k] = M_IDLE;
        m_sum[k] = 0;
        m_max[k] = 0;
        m_cnt[k] = 0;
        m_n[k] = 0;
      end
      pend.delete();
    end else begin
      while (pend.size() > 0 && pend[0].due == edge_n) begin
        m_e = pend.pop_front();
        m_sum[m_e.inst] += m_e.err;
        if (m_e.err > m_max[m_e.inst]) m_max[m_e.inst] = m_e.err;
        if (m_e.err != 0) m_cnt[m_e.inst] += 1;
      end
      case (m_phase[sel])
        M_IDLE: if (t_start) begin
          m_phase[sel] = M_RUN;
          m_sum[sel] = 0;
          m_max[sel] = 0;
          m_cnt[sel] = 0;
          m_n[sel] = 0;
        end
        M_RUN: if (t_valid) begin
          m_e.due = edge_n + 1;
          m_e.inst = sel;
          m_e.err = err_model(int'(t_a), int'(t_b), PV[sel]);
          pend.push_back(m_e);
          m_n[sel] += 1;
          if (m_n[sel] == NV[sel]) m_phase[sel] = M_DRAIN;
        end
        M_DRAIN: m_phase[sel] = M_DONE;
        M_DONE: if (t_res_ready) m_phase[sel] = M_IDLE;
        default: m_phase[sel] = M_IDLE;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  32'(d_in_ready),  32'(m_phase[sel] == M_RUN));
      chk("res_valid", 32'(d_res_valid), 32'(m_phase[sel] == M_DONE));
      chk("busy",      32'(d_busy),      32'(m_phase[sel] != M_IDLE));
      chk("err_sum",   32'(d_sum),       32'(m_sum[sel]));
      chk("err_max",   32'(d_max),       32'(m_max[sel]));
      chk("err_cnt",   32'(d_cnt),       32'(m_cnt[sel]));
    end
  end

  task automatic step(input logic st, input logic iv, input logic [3:0] aa,
                      input logic [3:0] bb, input logic rr);
    t_start = st;
    t_valid = iv;
    t_a = aa;
    t_b = bb;
    t_res_ready = rr;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic wait_res(input int bound);
    int k = 0;
    while (d_res_valid !== 1'b1 && k < bound) begin
      idle();
      k++;
    end
    if (d_res_valid !== 1'b1) chk("res_valid_timeout", 32'(d_res_valid), 32'd1);
  endtask

  task automatic expect_res(input string nm, input int s, input int m, input int c);
    chk({nm, "_sum"}, 32'(d_sum), 32'(s));
    chk({nm, "_max"}, 32'(d_max), 32'(m));
    chk({nm, "_cnt"}, 32'(d_cnt), 32'(c));
  endtask

  initial begin
    rst_n = 1'b0;
    sel = 0;
    idle();
    idle();
    chk_en = 1'b1;
    chk("rst_in_ready", 32'(d_in_ready), 32'd0);
    chk("rst_res_valid", 32'(d_res_valid), 32'd0);
    chk("rst_busy", 32'(d_busy), 32'd0);
    expect_res("rst", 0, 0, 0);
    rst_n = 1'b1;

    // P=2 N=4 back-to-back: errors 1,1,0,1
    step(1'b0, 1'b1, 4'd9, 4'd9, 1'b0);
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("run_in_ready", 32'(d_in_ready), 32'd1);
    step(1'b0, 1'b1, 4'd3, 4'd1, 1'b0);
    step(1'b0, 1'b1, 4'd15, 4'd15, 1'b0);
    step(1'b0, 1'b1, 4'd5, 4'd10, 1'b0);
    step(1'b0, 1'b1, 4'd3, 4'd1, 1'b0);
    chk("drain_in_ready", 32'(d_in_ready), 32'd0);
    chk("drain_res_valid", 32'(d_res_valid), 32'd0);
    idle();
    chk("a_res_valid", 32'(d_res_valid), 32'd1);
    expect_res("a", 3, 1, 3);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    chk("a_released", 32'(d_res_valid), 32'd0);
    idle();
    expect_res("a_retain", 3, 1, 3);

    // Same window with bubbles, stray starts and a slow consumer
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd3, 4'd1, 1'b0);
    step(1'b1, 1'b0, 4'd6, 4'd6, 1'b0);
    step(1'b0, 1'b1, 4'd15, 4'd15, 1'b0);
    idle();
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd5, 4'd10, 1'b0);
    step(1'b0, 1'b1, 4'd3, 4'd1, 1'b0);
    wait_res(10);
    for (int k = 0; k < 5; k++) begin
      expect_res("hold", 3, 1, 3);
      idle();
    end
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
    chk("start_in_done_busy", 32'(d_busy), 32'd0);
    idle();
    chk("no_new_window", 32'(d_busy), 32'd0);

    // P=0 N=8: exact adder, random operands
    sel = 1;
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    end
    wait_res(10);
    expect_res("p0", 0, 0, 0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);

    // P=3 N=1: (7,7) -> approx 15, valid on the third cycle from the accept cycle
    sel = 2;
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd7, 4'd7, 1'b0);
    chk("p3_drain_valid", 32'(d_res_valid), 32'd0);
    idle();
    chk("p3_res_valid", 32'(d_res_valid), 32'd1);
    expect_res("p3", 1, 1, 1);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);

    // Reset mid-window, then an unrelated window
    sel = 0;
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd15, 4'd15, 1'b0);
    step(1'b0, 1'b1, 4'd15, 4'd15, 1'b0);
    rst_n = 1'b0;
    idle();
    chk("mid_rst_busy", 32'(d_busy), 32'd0);
    chk("mid_rst_in_ready", 32'(d_in_ready), 32'd0);
    expect_res("mid_rst", 0, 0, 0);
    rst_n = 1'b1;
    idle();
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd5, 4'd10, 1'b0);
    step(1'b0, 1'b1, 4'd5, 4'd10, 1'b0);
    step(1'b0, 1'b1, 4'd3, 4'd1, 1'b0);
    step(1'b0, 1'b1, 4'd5, 4'd10, 1'b0);
    wait_res(10);
    expect_res("restart", 1, 1, 1);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/approx_err_meter.md
APPROX_ERR_METER -- requirements
Module: approx_err_meter

Interface
REQ-001 Parameter: P, 2, number of approximated low bits of the 4-bit approximate adder; legal 0..3.
REQ-002 Parameter: N, 16, samples per measurement window; legal 1..1024.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  begin a measurement window; sampled only in IDLE.
REQ-006 Port: in_valid  input  1  operand pair a/b valid.
REQ-007 Port: in_ready  output  1  block accepts operands this cycle.
REQ-008 Port: a  input  4  operand A.
REQ-009 Port: b  input  4  operand B.
REQ-010 Port: res_valid  output  1  window results valid and stable.
REQ-011 Port: res_ready  input  1  consumer takes results.
REQ-012 Port: err_sum  output  16  sum of |exact - approx| over window.
REQ-013 Port: err_max  output  5  largest |exact - approx| in window.
REQ-014 Port: err_cnt  output  11  number of samples with nonzero error.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 Exact sum SHALL be the 5-bit value a+b.
REQ-017 Approx sum bits i<P SHALL be a[i] OR b[i]; carry into bit P SHALL be a[P-1] AND b[P-1] (0 when P=0).
REQ-018 Approx bits P..3 SHALL be a full ripple/lookahead add of a, b with that carry; approx bit 4 SHALL be the carry out of bit 3.
REQ-019 Error per sample SHALL be unsigned 5-bit |exact - approx|.
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE: in_ready=0; start=1 -> RUN, clearing err_sum, err_max, err_cnt and sample counter to 0 in the same edge.
REQ-022 RUN: in_ready=1; a sample is accepted when in_valid AND in_ready; in_valid without in_ready SHALL be ignored.
REQ-023 Pipeline: accepted sample registered in stage 1 (error computed) on its accept edge; accumulators updated on the following edge (latency 2 edges from accept to accumulator update).
REQ-024 Accumulate: err_sum += err; err_max = max(err_max, err); err_cnt += 1 if err != 0; no overflow possible within legal N.
REQ-025 On the edge accepting the N-th sample, FSM SHALL go RUN -> DRAIN; in_ready SHALL be 0 from the next cycle.
REQ-026 DRAIN lasts exactly one cycle (last accumulation) then -> DONE.
REQ-027 DONE: res_valid=1, outputs held constant; res_ready=1 -> IDLE on that edge; res_valid low next cycle.
REQ-028 start outside IDLE SHALL be ignored; start and res_ready together in DONE SHALL only return to IDLE (no new window).
REQ-029 Bubbles (in_valid=0) in RUN SHALL not advance the counter or accumulators.
REQ-030 err_sum/err_max/err_cnt SHALL retain last window values in IDLE until the next start.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, in_ready=0, res_valid=0, busy=0, err_sum=0, err_max=0, err_cnt=0, counter and pipeline valid cleared, regardless of current state.
REQ-032 Reset mid-window SHALL discard in-flight samples; no partial result is ever presented.

Verification
REQ-033 P=2,N=4; start; samples (3,1),(15,15),(5,10),(3,1) back-to-back -> per-sample err 1,1,0,1; res_valid with err_sum=3, err_max=1, err_cnt=3.
REQ-034 P=0,N=8; random operands -> err_sum=0, err_max=0, err_cnt=0.
REQ-035 P=3,N=1; sample (7,7): exact 14, approx 15 -> err_sum=1, err_max=1, err_cnt=1; res_valid exactly 3 cycles after accept edge (stage1, accumulate/DRAIN, DONE).
REQ-036 P=2,N=4 with in_valid gaps and res_ready held low 5 cycles -> same results as REQ-033; outputs stable while res_valid=1; start pulses during RUN ignored.
REQ-037 Assert rst_n=0 after 2 accepted samples, then restart window -> all outputs 0 after reset; new window results independent of discarded samples.
